// File: rtl/controlador_display.sv
// Scan controller for a 4-digit common-anode 7-segment panel sharing one nibble decoder.
// Optional leading-zero suppression is enabled by defining CEROS_IZQ_EN.
module controlador_display #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dato,
    input  logic        cargar,
    input  logic [6:0]  salida_dec,
    output logic [3:0]  display,
    output logic [6:0]  segmentos,
    output logic [3:0]  anodos,
    output logic        ocupado
);

    localparam int unsigned PW = $clog2(DIV);

    typedef enum logic {
        BLANCO,
        MOSTRAR
    } estado_t;

    estado_t       estado, estado_sig;
    logic [PW-1:0] prescaler;
    logic [1:0]    indice, indice_sig;
    logic [15:0]   activo, pendiente, fuente;
    logic          tick, avanza, aplica, suprimir;
    logic [3:0]    nibble_sig;

    always_comb begin
        tick       = (prescaler == PW'(DIV - 1));
        avanza     = (estado == MOSTRAR) && tick;
        // Pending value takes over only on the 3 -> 0 edge, so a frame is never mixed.
        aplica     = avanza && (indice == 2'd3) && ocupado;
        fuente     = aplica ? pendiente : activo;
        indice_sig = indice + 2'd1;
        nibble_sig = fuente[{indice_sig, 2'b00} +: 4];
`ifdef CEROS_IZQ_EN
        suprimir   = (indice != 2'd0) && ((activo >> {indice, 2'b00}) == 16'h0000);
`else
        suprimir   = 1'b0;
`endif
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            BLANCO:  estado_sig = MOSTRAR;
            MOSTRAR: if (tick) estado_sig = BLANCO;
            default: estado_sig = BLANCO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= BLANCO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            indice    <= '0;
            activo    <= '0;
            pendiente <= '0;
            ocupado   <= 1'b0;
            display   <= '0;
            segmentos <= '1;
            anodos    <= '1;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;

            if (estado == BLANCO) begin
                if (suprimir) begin
                    segmentos <= '1;
                    anodos    <= '1;
                end else begin
                    segmentos <= salida_dec;
                    anodos    <= ~(4'b0001 << indice);
                end
            end else if (tick) begin
                segmentos <= '1;
                anodos    <= '1;
                indice    <= indice_sig;
                display   <= nibble_sig;
            end

            if (aplica) begin
                activo <= pendiente;
            end

            // A load on the wrap edge keeps ocupado set for the new pending value.
            if (cargar) begin
                pendiente <= dato;
                ocupado   <= 1'b1;
            end else if (aplica) begin
                ocupado   <= 1'b0;
            end
        end
    end

endmodule
